// File: rtl/inimigo_pkg.sv
// Shared geometry, timing defaults and widths for the enemy formation.
// Coordinates are carried in 11 bits so sums near the right edge cannot wrap.
package inimigo_pkg;

    localparam int COLS_PAD      = 8;
    localparam int ROWS_PAD      = 3;
    localparam int LARG_PAD      = 33;
    localparam int ALT_PAD       = 24;
    localparam int ESP_X_PAD     = 40;
    localparam int ESP_Y_PAD     = 32;
    localparam int PASSO_X_PAD   = 2;
    localparam int DESCIDA_PAD   = 20;
    localparam int X_MIN_PAD     = 0;
    localparam int X_MAX_PAD     = 639;
    localparam int Y_LIMITE_PAD  = 440;
    localparam int X_INI_PAD     = 40;
    localparam int Y_INI_PAD     = 40;
    localparam int DIV_INI_PAD   = 1000000;
    localparam int DIV_PASSO_PAD = 30000;
    localparam int DIV_MIN_PAD   = 100000;

    localparam int COORD_W = 11;
    localparam int IDX_W   = 8;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/divisor_movimento.sv
// Move-tick generator: one-cycle pulse every `periodo` enabled cycles.
// The period is compared live, so a shrink mid-count takes effect at once.
module divisor_movimento (
    input  logic        CLOCK_50,
    input  logic        resetInimigo,
    input  logic [31:0] periodo,
    input  logic        habilita,
    output logic        tick
);

    logic [31:0] contagem;

    assign tick = habilita && (contagem >= periodo - 32'd1);

    always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
        if (resetInimigo)
            contagem <= '0;
        else if (tick)
            contagem <= '0;
        else if (habilita)
            contagem <= contagem + 32'd1;
    end

endmodule

// File: rtl/inimigo_grade.sv
// ROWS x COLS enemy formation: shared origin, lateral sweep with descent,
// per-enemy hit detection against the player shot, invasion and all-dead flags.
module inimigo_grade
    import inimigo_pkg::*;
#(
    parameter int COLS      = COLS_PAD,
    parameter int ROWS      = ROWS_PAD,
    parameter int LARG      = LARG_PAD,
    parameter int ALT       = ALT_PAD,
    parameter int ESP_X     = ESP_X_PAD,
    parameter int ESP_Y     = ESP_Y_PAD,
    parameter int PASSO_X   = PASSO_X_PAD,
    parameter int DESCIDA   = DESCIDA_PAD,
    parameter int X_MIN     = X_MIN_PAD,
    parameter int X_MAX     = X_MAX_PAD,
    parameter int Y_LIMITE  = Y_LIMITE_PAD,
    parameter int X_INI     = X_INI_PAD,
    parameter int Y_INI     = Y_INI_PAD,
    parameter int DIV_INI   = DIV_INI_PAD,
    parameter int DIV_PASSO = DIV_PASSO_PAD,
    parameter int DIV_MIN   = DIV_MIN_PAD
) (
    input  logic                 CLOCK_50,
    input  logic                 resetInimigo,
    input  logic                 pausa,
    input  logic [9:0]           bola_x,
    input  logic [9:0]           bola_y,
    input  logic                 bola_valida,
    output logic                 acerto,
    output logic [IDX_W-1:0]     acerto_idx,
    output logic [ROWS*COLS-1:0] vivos,
    output logic [9:0]           x_grade,
    output logic [9:0]           y_grade,
    output logic                 sentido,
    output logic                 todos_mortos,
    output logic                 invadiu
);

    localparam int N = ROWS * COLS;

    coord_t             x_r, y_r, x_prox, y_prox;
    coord_t             borda_esq, borda_dir, ex, ey, bx, by;
    logic               sent_r, sent_prox, inv_r, inv_prox, trava;
    logic [N-1:0]       vivos_r, mata;
    logic [COLS-1:0]    col_viva;
    logic [ROWS-1:0]    lin_viva;
    logic               acerto_prox, tick, habilita, desce;
    logic [IDX_W-1:0]   idx_prox;
    logic [31:0]        periodo;
    int                 c_min, c_max, r_max, mortos, p;

    assign bx = {1'b0, bola_x};
    assign by = {1'b0, bola_y};

    // Formation extent comes only from columns/rows that still hold a live enemy.
    always_comb begin
        col_viva = '0;
        lin_viva = '0;
        mortos   = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (vivos_r[r*COLS+c]) begin
                    col_viva[c] = 1'b1;
                    lin_viva[r] = 1'b1;
                end else
                    mortos++;
        c_min = 0;
        c_max = 0;
        r_max = 0;
        for (int c = COLS-1; c >= 0; c--) if (col_viva[c]) c_min = c;
        for (int c = 0; c < COLS; c++)    if (col_viva[c]) c_max = c;
        for (int r = 0; r < ROWS; r++)    if (lin_viva[r]) r_max = r;
        p = DIV_INI - mortos * DIV_PASSO;
        if (p < DIV_MIN) p = DIV_MIN;
    end

    assign periodo   = p;
    assign borda_esq = x_r + coord_t'(c_min * ESP_X);
    assign borda_dir = x_r + coord_t'(c_max * ESP_X + LARG - 1);
    assign habilita  = !pausa && !todos_mortos && !inv_r;

    divisor_movimento u_divisor (
        .CLOCK_50     (CLOCK_50),
        .resetInimigo (resetInimigo),
        .periodo      (periodo),
        .habilita     (habilita),
        .tick         (tick)
    );

    // A tick either steps laterally or descends and reverses, never both.
    always_comb begin
        x_prox    = x_r;
        y_prox    = y_r;
        sent_prox = sent_r;
        inv_prox  = inv_r;
        desce     = 1'b0;
        if (tick) begin
            if (sent_r) begin
                if (borda_dir + coord_t'(PASSO_X) > coord_t'(X_MAX)) desce = 1'b1;
                else x_prox = x_r + coord_t'(PASSO_X);
            end else begin
                if (borda_esq < coord_t'(X_MIN + PASSO_X)) desce = 1'b1;
                else x_prox = x_r - coord_t'(PASSO_X);
            end
            if (desce) begin
                y_prox    = y_r + coord_t'(DESCIDA);
                sent_prox = !sent_r;
                if (y_prox + coord_t'(r_max * ESP_Y + ALT) >= coord_t'(Y_LIMITE))
                    inv_prox = 1'b1;
            end
        end
    end

    // Scan from the top index down so the lowest-index candidate is the one kept.
    always_comb begin
        acerto_prox = 1'b0;
        idx_prox    = '0;
        mata        = '0;
        ex          = '0;
        ey          = '0;
        if (bola_valida && !pausa && !trava) begin
            for (int i = N-1; i >= 0; i--) begin
                ex = x_r + coord_t'((i % COLS) * ESP_X);
                ey = y_r + coord_t'((i / COLS) * ESP_Y);
                if (vivos_r[i] && bx > ex && bx < ex + coord_t'(LARG) &&
                    by > ey && by < ey + coord_t'(ALT)) begin
                    acerto_prox = 1'b1;
                    idx_prox    = IDX_W'(i);
                    mata        = '0;
                    mata[i]     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
        if (resetInimigo) begin
            x_r        <= coord_t'(X_INI);
            y_r        <= coord_t'(Y_INI);
            sent_r     <= 1'b1;
            inv_r      <= 1'b0;
            vivos_r    <= '1;
            acerto     <= 1'b0;
            acerto_idx <= '0;
            trava      <= 1'b0;
        end else begin
            x_r     <= x_prox;
            y_r     <= y_prox;
            sent_r  <= sent_prox;
            inv_r   <= inv_prox;
            vivos_r <= vivos_r & ~mata;
            acerto  <= acerto_prox;
            if (acerto_prox) acerto_idx <= idx_prox;
            // The lock lasts for the whole flight of the shot that scored.
            if (acerto_prox)       trava <= 1'b1;
            else if (!bola_valida) trava <= 1'b0;
        end
    end

    assign vivos        = vivos_r;
    assign x_grade      = x_r[9:0];
    assign y_grade      = y_r[9:0];
    assign sentido      = sent_r;
    assign invadiu      = inv_r;
    assign todos_mortos = (vivos_r == '0);

endmodule

// File: tb/tb_inimigo_grade.sv
// Directed bench for inimigo_grade with a fast divider (10/1/8) and a high
// invasion line (200) so sweeps, reversals and invasion fit in a short run.
module tb_inimigo_grade;

    localparam int COLS = 8;
    localparam int N    = 24;

    logic          CLOCK_50, resetInimigo, pausa, bola_valida;
    logic [9:0]    bola_x, bola_y;
    logic          acerto, sentido, todos_mortos, invadiu;
    logic [7:0]    acerto_idx;
    logic [N-1:0]  vivos;
    logic [9:0]    x_grade, y_grade;

    int vectors     = 0;
    int miscompares = 0;

    inimigo_grade #(
        .DIV_INI   (10),
        .DIV_PASSO (1),
        .DIV_MIN   (8),
        .Y_LIMITE  (200)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .resetInimigo (resetInimigo),
        .pausa        (pausa),
        .bola_x       (bola_x),
        .bola_y       (bola_y),
        .bola_valida  (bola_valida),
        .acerto       (acerto),
        .acerto_idx   (acerto_idx),
        .vivos        (vivos),
        .x_grade      (x_grade),
        .y_grade      (y_grade),
        .sentido      (sentido),
        .todos_mortos (todos_mortos),
        .invadiu      (invadiu)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Aim at enemy idx in a formation whose origin is (x0, 40); off_x is the offset into the cell.
    task automatic aim(input int idx, input int x0, input int off_x);
        bola_x = 10'(x0 + (idx % COLS) * 40 + off_x);
        bola_y = 10'(40 + (idx / COLS) * 32 + 12);
    endtask

    // Waits (bounded) for the formation position or direction to change.
    task automatic wait_move(output int cycles, output bit ok);
        logic [20:0] antes;
        antes  = {x_grade, y_grade, sentido};
        cycles = 0;
        ok     = 1'b0;
        while (!ok && cycles < 20) begin
            @(negedge CLOCK_50);
            cycles++;
            if ({x_grade, y_grade, sentido} !== antes) ok = 1'b1;
        end
    endtask

    task automatic hold_reset();
        @(negedge CLOCK_50);
        resetInimigo = 1'b1;
        bola_valida  = 1'b0;
        pausa        = 1'b0;
        @(negedge CLOCK_50);
    endtask

    // One lateral leg from x0 to the reversal column x_turn, then the descent tick.
    task automatic run_leg(input int x0, input int x_turn, input int y0, input bit dir);
        int cyc, n, exp_x;
        bit ok, bad;
        bad = 1'b0;
        n = (dir ? (x_turn - x0) : (x0 - x_turn)) / 2;
        for (int i = 1; i <= n && !bad; i++) begin
            wait_move(cyc, ok);
            exp_x = dir ? x0 + 2*i : x0 - 2*i;
            vectors++;
            if (!ok || x_grade !== 10'(exp_x) || y_grade !== 10'(y0)) begin
                miscompares++;
                bad = 1'b1;
                $display("FAIL leg_step: moved=%0b x=%0d y=%0d, expected x=%0d y=%0d",
                         ok, x_grade, y_grade, exp_x, y0);
            end
        end
        if (!bad) begin
            wait_move(cyc, ok);
            vectors++;
            if (!ok || x_grade !== 10'(x_turn) || y_grade !== 10'(y0 + 20) || sentido !== ~dir) begin
                miscompares++;
                $display("FAIL leg_turn: moved=%0b x=%0d y=%0d sentido=%0b, expected x=%0d y=%0d sentido=%0b",
                         ok, x_grade, y_grade, sentido, x_turn, y0 + 20, ~dir);
            end
        end
    endtask

    task automatic test_reset();
        resetInimigo = 1'b1;
        pausa        = 1'b0;
        bola_valida  = 1'b0;
        bola_x       = '0;
        bola_y       = '0;
        repeat (3) @(negedge CLOCK_50);
        vectors++;
        if (x_grade !== 10'd40 || y_grade !== 10'd40 || sentido !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pos: x=%0d y=%0d sentido=%0b, expected 40 40 1", x_grade, y_grade, sentido);
        end
        vectors++;
        if (vivos !== 24'hFFFFFF || todos_mortos !== 1'b0 || invadiu !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: vivos=%h todos=%0b invadiu=%0b, expected ffffff 0 0", vivos, todos_mortos, invadiu);
        end
        vectors++;
        if (acerto !== 1'b0 || acerto_idx !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_hit: acerto=%0b idx=%0d, expected 0 0", acerto, acerto_idx);
        end
    endtask

    task automatic test_sweep();
        resetInimigo = 1'b0;
        repeat (9) @(negedge CLOCK_50);
        vectors++;
        if (x_grade !== 10'd40) begin
            miscompares++;
            $display("FAIL sweep_before_tick: x=%0d, expected 40", x_grade);
        end
        @(negedge CLOCK_50);
        vectors++;
        if (x_grade !== 10'd42 || sentido !== 1'b1 || vivos !== 24'hFFFFFF) begin
            miscompares++;
            $display("FAIL sweep_tick1: x=%0d sentido=%0b vivos=%h, expected 42 1 ffffff", x_grade, sentido, vivos);
        end
        repeat (10) @(negedge CLOCK_50);
        vectors++;
        if (x_grade !== 10'd44) begin
            miscompares++;
            $display("FAIL sweep_tick2: x=%0d, expected 44", x_grade);
        end
    endtask

    task automatic test_edge_right();
        run_leg(44, 326, 40, 1'b1);
    endtask

    task automatic test_invasion();
        run_leg(326, 0, 60, 1'b0);
        run_leg(0, 326, 80, 1'b1);
        vectors++;
        if (invadiu !== 1'b0) begin
            miscompares++;
            $display("FAIL invasion_early: invadiu=%0b at y=%0d, expected 0", invadiu, y_grade);
        end
        run_leg(326, 0, 100, 1'b0);
        vectors++;
        if (invadiu !== 1'b1) begin
            miscompares++;
            $display("FAIL invasion_flag: invadiu=%0b at y=%0d, expected 1", invadiu, y_grade);
        end
        repeat (30) @(negedge CLOCK_50);
        vectors++;
        if (x_grade !== 10'd0 || y_grade !== 10'd120 || invadiu !== 1'b1) begin
            miscompares++;
            $display("FAIL invasion_frozen: x=%0d y=%0d invadiu=%0b, expected 0 120 1", x_grade, y_grade, invadiu);
        end
    endtask

    task automatic test_hit_lock();
        int pulses;
        hold_reset();
        aim(0, 40, 16);
        bola_valida  = 1'b1;
        resetInimigo = 1'b0;
        @(negedge CLOCK_50);
        vectors++;
        if (acerto !== 1'b1 || acerto_idx !== 8'd0 || vivos !== 24'hFFFFFE) begin
            miscompares++;
            $display("FAIL hit_first: acerto=%0b idx=%0d vivos=%h, expected 1 0 fffffe", acerto, acerto_idx, vivos);
        end
        pulses = 0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge CLOCK_50);
            if (acerto === 1'b1) pulses++;
            if (k == 3) aim(1, 40, 16);
        end
        vectors++;
        if (pulses != 0 || vivos !== 24'hFFFFFE || acerto_idx !== 8'd0) begin
            miscompares++;
            $display("FAIL hit_lock: extra_pulses=%0d vivos=%h idx=%0d, expected 0 fffffe 0", pulses, vivos, acerto_idx);
        end
        bola_valida = 1'b0;
        @(negedge CLOCK_50);
        bola_valida = 1'b1;
        @(negedge CLOCK_50);
        vectors++;
        if (acerto !== 1'b1 || acerto_idx !== 8'd1 || vivos !== 24'hFFFFFC || x_grade !== 10'd40) begin
            miscompares++;
            $display("FAIL hit_second: acerto=%0b idx=%0d vivos=%h x=%0d, expected 1 1 fffffc 40",
                     acerto, acerto_idx, vivos, x_grade);
        end
        bola_valida = 1'b0;
        @(negedge CLOCK_50);
        vectors++;
        if (acerto !== 1'b0 || acerto_idx !== 8'd1 || x_grade !== 10'd42) begin
            miscompares++;
            $display("FAIL hit_after: acerto=%0b idx=%0d x=%0d, expected 0 1 42", acerto, acerto_idx, x_grade);
        end
    endtask

    task automatic test_col7_and_pause();
        int cyc, pulses;
        bit ok;
        logic [23:0] exp_v;
        hold_reset();
        exp_v = 24'hFFFFFF;
        for (int r = 0; r < 3; r++) begin
            aim(r*8 + 7, 40, 16);
            bola_valida  = 1'b1;
            resetInimigo = 1'b0;
            @(negedge CLOCK_50);
            exp_v[r*8 + 7] = 1'b0;
            vectors++;
            if (acerto !== 1'b1 || acerto_idx !== 8'(r*8 + 7) || vivos !== exp_v) begin
                miscompares++;
                $display("FAIL col7_kill: acerto=%0b idx=%0d vivos=%h, expected 1 %0d %h",
                         acerto, acerto_idx, vivos, r*8 + 7, exp_v);
            end
            bola_valida = 1'b0;
            if (r < 2) @(negedge CLOCK_50);
        end
        wait_move(cyc, ok);
        vectors++;
        if (!ok || cyc != 3 || x_grade !== 10'd42) begin
            miscompares++;
            $display("FAIL col7_first_tick: moved=%0b after=%0d x=%0d, expected 1 3 42", ok, cyc, x_grade);
        end
        wait_move(cyc, ok);
        vectors++;
        if (!ok || cyc != 8 || x_grade !== 10'd44) begin
            miscompares++;
            $display("FAIL period_clamp: moved=%0b period=%0d x=%0d, expected 1 8 44", ok, cyc, x_grade);
        end
        run_leg(44, 366, 40, 1'b1);
        pausa       = 1'b1;
        bola_x      = 10'd382;
        bola_y      = 10'd72;
        bola_valida = 1'b1;
        pulses      = 0;
        repeat (30) begin
            @(negedge CLOCK_50);
            if (acerto === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0 || x_grade !== 10'd366 || y_grade !== 10'd60 || vivos !== 24'h7F7F7F) begin
            miscompares++;
            $display("FAIL pause_freeze: pulses=%0d x=%0d y=%0d vivos=%h, expected 0 366 60 7f7f7f",
                     pulses, x_grade, y_grade, vivos);
        end
        pausa       = 1'b0;
        bola_valida = 1'b0;
        wait_move(cyc, ok);
        vectors++;
        if (!ok || cyc != 8 || x_grade !== 10'd364 || sentido !== 1'b0) begin
            miscompares++;
            $display("FAIL pause_resume: moved=%0b after=%0d x=%0d sentido=%0b, expected 1 8 364 0",
                     ok, cyc, x_grade, sentido);
        end
    endtask

    task automatic test_all_dead();
        hold_reset();
        for (int k = 0; k < N; k++) begin
            aim(k, 40, 24);
            bola_valida  = 1'b1;
            resetInimigo = 1'b0;
            @(negedge CLOCK_50);
            vectors++;
            if (acerto !== 1'b1 || acerto_idx !== 8'(k)) begin
                miscompares++;
                $display("FAIL kill_all: acerto=%0b idx=%0d, expected 1 %0d", acerto, acerto_idx, k);
            end
            bola_valida = 1'b0;
            @(negedge CLOCK_50);
        end
        vectors++;
        if (todos_mortos !== 1'b1 || vivos !== 24'h0 || x_grade !== 10'd50) begin
            miscompares++;
            $display("FAIL all_dead: todos=%0b vivos=%h x=%0d, expected 1 000000 50", todos_mortos, vivos, x_grade);
        end
        repeat (40) @(negedge CLOCK_50);
        vectors++;
        if (x_grade !== 10'd50 || y_grade !== 10'd40) begin
            miscompares++;
            $display("FAIL all_dead_frozen: x=%0d y=%0d, expected 50 40", x_grade, y_grade);
        end
    endtask

    task automatic test_reset_mid();
        #5;
        resetInimigo = 1'b1;
        #1;
        vectors++;
        if (x_grade !== 10'd40 || y_grade !== 10'd40 || sentido !== 1'b1 || vivos !== 24'hFFFFFF ||
            acerto_idx !== 8'd0 || acerto !== 1'b0 || todos_mortos !== 1'b0 || invadiu !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: x=%0d y=%0d s=%0b vivos=%h idx=%0d acerto=%0b todos=%0b inv=%0b, expected 40 40 1 ffffff 0 0 0 0",
                     x_grade, y_grade, sentido, vivos, acerto_idx, acerto, todos_mortos, invadiu);
        end
        @(negedge CLOCK_50);
        resetInimigo = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_edge_right();
        test_invasion();
        test_hit_lock();
        test_col7_and_pause();
        test_all_dead();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
